zap_regf_bram_mp: RTL
=====================

Name: zap_regf_bram_mp

Overview:
- Parametrised multi-port register-file RAM, the next generation of the 2-write/1-read register-file block RAM.
- Two independent write ports, each with its own enable, and NUM_RD registered read ports.
- Configurable write-to-read bypass and deterministic write-collision priority.
- A post-reset init sequencer walks the array and loads INIT_VAL. This replaces the simulation-only initial block, so contents are defined after every reset in silicon too.

Parameters:
- DATA_WDT, 32: data width in bits.
- ADDR_WDT, 6: address width in bits.
- DEPTH, 64: number of entries; must satisfy 2 ≤ DEPTH ≤ 2^ADDR_WDT.
- NUM_RD, 2: number of read ports; must be ≥ 1.
- BYPASS, 1: 1 means a same-cycle write is forwarded to a matching read; 0 means the read returns old data.
- INIT_VAL, 0: value loaded into every entry by the init sequencer.

Ports:
- i_clk  in  1  single clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_wen_a  in  1  write enable, port A.
- i_waddr_a  in  ADDR_WDT  write address, port A.
- i_wdata_a  in  DATA_WDT  write data, port A.
- i_wen_b  in  1  write enable, port B.
- i_waddr_b  in  ADDR_WDT  write address, port B.
- i_wdata_b  in  DATA_WDT  write data, port B.
- i_rd_en  in  NUM_RD  per-port read enable.
- i_raddr  in  NUM_RD*ADDR_WDT  read addresses, flattened; port k occupies bits [k*ADDR_WDT +: ADDR_WDT].
- o_rd_data  out  NUM_RD*DATA_WDT  registered read data, flattened the same way.
- o_rd_valid  out  NUM_RD  per-port read data valid.
- o_init_done  out  1  high once the array is initialised.

Behaviour:
- Reset (asynchronous, i_reset_n low):
  - FSM goes to INIT; init counter = 0.
  - o_init_done = 0, o_rd_valid = 0, o_rd_data = 0.
  - Reset asserted at any time, including mid-INIT, restarts the sequence from address 0.
- State INIT:
  - Each posedge writes INIT_VAL to mem[cnt], then cnt increments.
  - The posedge that writes DEPTH-1 moves the FSM to RUN and registers o_init_done = 1.
  - o_init_done therefore rises exactly DEPTH posedges after reset release.
  - All user writes are ignored; o_rd_valid is forced 0; o_rd_data holds 0.
- State RUN: terminal until the next reset; o_init_done stays 1.
- Writes (RUN only):
  - On a posedge, mem[i_waddr_a] is updated if i_wen_a; mem[i_waddr_b] is updated if i_wen_b.
  - Both enabled at the same address: port B wins and port A is discarded.
  - Any address ≥ DEPTH: that write is dropped with no side effect.
- Reads (RUN only), latency 1:
  - When i_rd_en[k] is high at posedge t, o_rd_data[k] holds the result and o_rd_valid[k] = 1 from t until the next posedge.
  - When i_rd_en[k] is low: o_rd_valid[k] = 0 and o_rd_data[k] holds its previous value.
  - Read address ≥ DEPTH: data returned is 0, with valid asserted.
  - Read ports are fully independent; any number may share an address.
- Read-during-write to the same address, same posedge:
  - BYPASS=1: returns the newly written data; if both write ports match, port B data is returned.
  - BYPASS=0: returns the pre-write contents.
  - A dropped (out-of-range) write is never forwarded.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. Release reset; count posedges to o_init_done → it rises on posedge 64 (DEPTH=64). Then read addresses 0, 31, 63 → all return 0 with o_rd_valid=1 one cycle later.
2. In RUN, write A: addr 5 = 0xDEADBEEF and B: addr 6 = 0x12345678 together; next cycle read port0 = 5, port1 = 6 → 0xDEADBEEF, 0x12345678.
3. Write A and B both to addr 9 (A = 0x1, B = 0x2), then read 9 → 0x2.
4. Same posedge: write B addr 3 = 0xCAFE and read port0 addr 3 (old value 0x0) → 0xCAFE with BYPASS=1; 0x0 with BYPASS=0. The following read of addr 3 returns 0xCAFE in both builds.
5. Assert i_reset_n low after 30 INIT cycles, then release → o_init_done rises 64 posedges after the release. During INIT, a write with i_wen_a high to addr 0 = 0xFF is ignored; addr 0 reads 0 after init.
6. With DEPTH=40, ADDR_WDT=6: write addr 50 = 0xAA and read addr 50 → read data 0, valid=1. Addresses 0–39 are unchanged; o_rd_valid follows i_rd_en with exactly 1-cycle delay.

Source files
------------

// File: rtl/zap_regf_bram_mp_if.sv
// Bus bundle for the multi-port register-file RAM: two write ports, NUM_RD
// registered read ports and the init-done flag. Clock and reset stay outside.
interface zap_regf_bram_mp_if #(
   parameter int unsigned DATA_WDT = 32,
   parameter int unsigned ADDR_WDT = 6,
   parameter int unsigned NUM_RD   = 2
);

   // Write port A
   logic                         i_wen_a;
   logic [ADDR_WDT-1:0]          i_waddr_a;
   logic [DATA_WDT-1:0]          i_wdata_a;

   // Write port B (wins over A on an address collision)
   logic                         i_wen_b;
   logic [ADDR_WDT-1:0]          i_waddr_b;
   logic [DATA_WDT-1:0]          i_wdata_b;

   // Read ports, flattened: port k at [k*WIDTH +: WIDTH]
   logic [NUM_RD-1:0]            i_rd_en;
   logic [NUM_RD*ADDR_WDT-1:0]   i_raddr;
   logic [NUM_RD*DATA_WDT-1:0]   o_rd_data;
   logic [NUM_RD-1:0]            o_rd_valid;

   logic                         o_init_done;

   // Requester side
   modport master (
      output i_wen_a, i_waddr_a, i_wdata_a,
      output i_wen_b, i_waddr_b, i_wdata_b,
      output i_rd_en, i_raddr,
      input  o_rd_data, o_rd_valid, o_init_done
   );

   // RAM side
   modport slave (
      input  i_wen_a, i_waddr_a, i_wdata_a,
      input  i_wen_b, i_waddr_b, i_wdata_b,
      input  i_rd_en, i_raddr,
      output o_rd_data, o_rd_valid, o_init_done
   );

endinterface

// File: rtl/zap_regf_bram_mp.sv
// Multi-port register-file RAM: two write ports, NUM_RD registered read ports,
// optional write-to-read bypass, and a post-reset sequencer that loads INIT_VAL
// into every entry so contents are defined after each reset.
// DEPTH must lie in [2, 2**ADDR_WDT] and NUM_RD must be at least 1.
module zap_regf_bram_mp #(
   parameter int unsigned          DATA_WDT = 32,
   parameter int unsigned          ADDR_WDT = 6,
   parameter int unsigned          DEPTH    = 64,
   parameter int unsigned          NUM_RD   = 2,
   parameter bit                   BYPASS   = 1'b1,
   parameter logic [DATA_WDT-1:0]  INIT_VAL = '0
) (
   input logic                i_clk,
   input logic                i_reset_n,
   zap_regf_bram_mp_if.slave  bus
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   typedef logic [ADDR_WDT-1:0] addr_t;
   typedef logic [DATA_WDT-1:0] data_t;

   typedef enum logic [0:0] {
      StInit,
      StRun
   } state_e;

   // True when an address maps onto a real entry; others are silently dropped.
   function automatic logic in_range(input addr_t a);
      return 32'(a) < DEPTH;
   endfunction

   state_e                  state_q, state_d;
   addr_t                   cnt_q, cnt_d;
   logic                    init_done_q, init_done_d;

   data_t                   mem [DEPTH];

   logic                    run;
   logic                    wr_a_ok, wr_b_ok;
   addr_t                   raddr [NUM_RD];

   logic  [NUM_RD-1:0]      rd_valid_q, rd_valid_d;
   data_t [NUM_RD-1:0]      rd_data_q, rd_data_d;

   assign run = (state_q == StRun);

   // Qualified write strobes; A is suppressed when B hits the same address.
   always_comb begin
      wr_b_ok = run && bus.i_wen_b && in_range(bus.i_waddr_b);
      wr_a_ok = run && bus.i_wen_a && in_range(bus.i_waddr_a) &&
                !(bus.i_wen_b && (bus.i_waddr_b == bus.i_waddr_a));
   end

   // Init sequencer next-state: walk 0..DEPTH-1, then park in RUN until reset.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_done_d = init_done_q;
      unique case (state_q)
         StInit: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == addr_t'(DEPTH - 1)) begin
               state_d     = StRun;
               cnt_d       = '0;
               init_done_d = 1'b1;
            end
         end
         StRun: begin
            state_d = StRun;
         end
         default: begin
            state_d = StInit;
            cnt_d   = '0;
         end
      endcase
   end

   // Sequencer state registers; any reset restarts the walk from address 0.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q     <= StInit;
         cnt_q       <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         init_done_q <= init_done_d;
      end
   end

   // Storage array: init sequencer owns it in INIT, user ports in RUN.
   always_ff @(posedge i_clk) begin
      if (state_q == StInit) begin
         mem[cnt_q[IDX_W-1:0]] <= INIT_VAL;
      end else begin
         if (wr_a_ok) begin
            mem[bus.i_waddr_a[IDX_W-1:0]] <= bus.i_wdata_a;
         end
         if (wr_b_ok) begin
            mem[bus.i_waddr_b[IDX_W-1:0]] <= bus.i_wdata_b;
         end
      end
   end

   // Unpack the flattened read address bus.
   always_comb begin
      for (int k = 0; k < NUM_RD; k++) begin
         raddr[k] = bus.i_raddr[k*ADDR_WDT +: ADDR_WDT];
      end
   end

   // Read next-state: idle ports hold data and drop valid; B bypass beats A.
   always_comb begin
      rd_valid_d = '0;
      rd_data_d  = rd_data_q;
      for (int k = 0; k < NUM_RD; k++) begin
         if (run && bus.i_rd_en[k]) begin
            rd_valid_d[k] = 1'b1;
            if (!in_range(raddr[k])) begin
               rd_data_d[k] = '0;
            end else if (BYPASS && wr_b_ok && (bus.i_waddr_b == raddr[k])) begin
               rd_data_d[k] = bus.i_wdata_b;
            end else if (BYPASS && wr_a_ok && (bus.i_waddr_a == raddr[k])) begin
               rd_data_d[k] = bus.i_wdata_a;
            end else begin
               rd_data_d[k] = mem[raddr[k][IDX_W-1:0]];
            end
         end
      end
   end

   // Registered read outputs.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         rd_valid_q <= '0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign bus.o_rd_valid  = rd_valid_q;
   assign bus.o_rd_data   = rd_data_q;
   assign bus.o_init_done = init_done_q;

endmodule
